// File: rtl/switch_out_arb.sv
// switch_out_arb: round-robin drain of four switch output ports into one
// byte-stream sink. Packets are DA, SA, LEN, LEN payload bytes, FCS.
// Per-port completed-packet counters are built only when the macro
// SWITCH_OUT_ARB_STATS_EN is defined; otherwise pkt_cnt is tied to zero.
module switch_out_arb #(
    parameter int STATS_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ready_0,
    input  logic                 ready_1,
    input  logic                 ready_2,
    input  logic                 ready_3,
    input  logic [7:0]           port0,
    input  logic [7:0]           port1,
    input  logic [7:0]           port2,
    input  logic [7:0]           port3,
    output logic                 read_0,
    output logic                 read_1,
    output logic                 read_2,
    output logic                 read_3,
    input  logic                 sink_ready,
    output logic                 sink_valid,
    output logic [7:0]           sink_data,
    output logic                 sink_sop,
    output logic                 sink_eop,
    output logic [1:0]           sink_port,
    output logic                 pkt_err,
    output logic [4*STATS_W-1:0] pkt_cnt
);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t          state;
    logic [1:0]      last_grant;
    logic [8:0]      rd_cnt;
    logic [8:0]      total;
    logic [8:0]      byte_idx;
    logic [3:0]      ready_v;
    logic [3:0]      read_v;
    logic [3:0][7:0] port_v;
    logic [7:0]      port_sel;
    logic            ready_sel;
    logic            len_now;
    logic [8:0]      total_eff;
    logic            rd_fire;
    logic            rd_last;
    logic            abort;
    logic            found;
    logic [1:0]      pick;
    logic [1:0]      cand;

    assign ready_v   = {ready_3, ready_2, ready_1, ready_0};
    assign port_v    = {port3, port2, port1, port0};
    assign port_sel  = port_v[sink_port];
    assign ready_sel = ready_v[sink_port];

    // The LEN byte is on the bus the cycle after read index 2; using it
    // directly lets the very next read compare against the final length.
    assign len_now   = sink_valid && (byte_idx == 9'd2);
    assign total_eff = len_now ? ({1'b0, port_sel} + 9'd4) : total;

    assign rd_fire = (state == XFER) && sink_ready && ready_sel && (rd_cnt < total_eff);
    assign rd_last = rd_fire && ((rd_cnt + 9'd1) == total_eff);
    assign abort   = (state == XFER) && !ready_sel && (rd_cnt < total_eff);

    assign read_v = rd_fire ? (4'b0001 << sink_port) : 4'b0000;
    assign {read_3, read_2, read_1, read_0} = read_v;

    // Source data arrives one cycle after the pop, so the sink sees it
    // straight from the port mux; gating keeps the bus at zero when idle.
    assign sink_data = sink_valid ? port_sel : 8'h00;
    assign sink_sop  = sink_valid && (byte_idx == 9'd0);
    assign sink_eop  = sink_valid && (byte_idx == (total_eff - 9'd1));

    // Round-robin search starting one past the last granted port
    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        cand  = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!found && ready_v[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Arbitration FSM plus read bookkeeping and registered sink strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            rd_cnt     <= 9'd0;
            total      <= 9'd4;
            byte_idx   <= 9'd0;
            sink_valid <= 1'b0;
            sink_port  <= 2'd0;
            pkt_err    <= 1'b0;
        end else begin
            sink_valid <= rd_fire;
            pkt_err    <= abort;
            if (rd_fire) begin
                byte_idx <= rd_cnt;
                rd_cnt   <= rd_cnt + 9'd1;
            end
            if (len_now) total <= total_eff;
            case (state)
                IDLE: begin
                    rd_cnt <= 9'd0;
                    total  <= 9'd4;
                    if (found) begin
                        sink_port <= pick;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (abort) begin
                        last_grant <= sink_port;
                        state      <= IDLE;
                    end else if (rd_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    last_grant <= sink_port;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SWITCH_OUT_ARB_STATS_EN
    logic [3:0][STATS_W-1:0] cnt;

    // A packet completes in DRAIN; aborted packets never reach it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (state == DRAIN) cnt[sink_port] <= cnt[sink_port] + STATS_W'(1);
    end

    assign pkt_cnt = cnt;
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_switch_out_arb.sv
// Directed bench for switch_out_arb: per-port byte sources, sink logger,
// one task per scenario with inline comparisons.
module tb_switch_out_arb;

    localparam int SW = 16;
`ifdef SWITCH_OUT_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ready_0, ready_1, ready_2, ready_3;
    logic [7:0] port0, port1, port2, port3;
    logic read_0, read_1, read_2, read_3;
    logic sink_ready = 1'b1;
    logic sink_valid, sink_sop, sink_eop, pkt_err;
    logic [7:0] sink_data;
    logic [1:0] sink_port;
    logic [4*SW-1:0] pkt_cnt;

    int nchk = 0;
    int nerr = 0;

    // source model
    logic [7:0] mem [4][1024];
    int         wr_ptr [4] = '{default: 0};
    int         rd_ptr [4] = '{default: 0};
    logic [7:0] pdat [4] = '{default: 8'h00};
    logic [3:0] hold = 4'b0000;
    logic [3:0] rdv;

    // sink log
    logic [7:0] log_data [4096];
    logic       log_sop [4096];
    logic       log_eop [4096];
    logic [1:0] log_port [4096];
    int nb = 0;
    int rd_seen [4] = '{default: 0};
    int multi = 0;
    int err_seen = 0;
    int mcnt [4] = '{default: 0};

    always #5 clk = ~clk;

    assign ready_0 = (rd_ptr[0] < wr_ptr[0]) && !hold[0];
    assign ready_1 = (rd_ptr[1] < wr_ptr[1]) && !hold[1];
    assign ready_2 = (rd_ptr[2] < wr_ptr[2]) && !hold[2];
    assign ready_3 = (rd_ptr[3] < wr_ptr[3]) && !hold[3];
    assign port0 = pdat[0];
    assign port1 = pdat[1];
    assign port2 = pdat[2];
    assign port3 = pdat[3];
    assign rdv = {read_3, read_2, read_1, read_0};

    switch_out_arb #(.STATS_W(SW)) dut (
        .clk(clk), .reset(reset),
        .ready_0(ready_0), .ready_1(ready_1), .ready_2(ready_2), .ready_3(ready_3),
        .port0(port0), .port1(port1), .port2(port2), .port3(port3),
        .read_0(read_0), .read_1(read_1), .read_2(read_2), .read_3(read_3),
        .sink_ready(sink_ready), .sink_valid(sink_valid), .sink_data(sink_data),
        .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_port(sink_port),
        .pkt_err(pkt_err), .pkt_cnt(pkt_cnt)
    );

    // pop a byte on each read; data valid the following cycle
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (rdv[n]) begin
                pdat[n]   <= mem[n][rd_ptr[n]];
                rd_ptr[n] <= rd_ptr[n] + 1;
            end
        end
    end

    // log sink bytes and read activity mid-cycle
    always @(negedge clk) begin
        if (sink_valid) begin
            log_data[nb] = sink_data;
            log_sop[nb]  = sink_sop;
            log_eop[nb]  = sink_eop;
            log_port[nb] = sink_port;
            nb = nb + 1;
        end
        for (int n = 0; n < 4; n++) if (rdv[n]) rd_seen[n] = rd_seen[n] + 1;
        if ($countones(rdv) > 1) multi = multi + 1;
        if (pkt_err) err_seen = err_seen + 1;
    end

    task automatic load_pkt(input int n, input int len, output int ms);
        int p;
        p  = wr_ptr[n];
        ms = p;
        mem[n][p]     = 8'(8'hD0 + n);
        mem[n][p + 1] = 8'(8'h50 + n);
        mem[n][p + 2] = 8'(len);
        for (int i = 0; i < len; i++) mem[n][p + 3 + i] = 8'(n * 37 + i * 7 + len);
        mem[n][p + 3 + len] = 8'hFC;
        wr_ptr[n] = p + len + 4;
    endtask

    task automatic wait_bytes(input int target, output bit ok);
        int c;
        c  = 0;
        ok = 1'b1;
        while (nb < target) begin
            @(posedge clk); #1;
            c++;
            if (c > 1000) begin ok = 1'b0; break; end
        end
    endtask

    task automatic wait_reads(input int n, input int target, output bit ok);
        int c;
        c  = 0;
        ok = 1'b1;
        while (rd_seen[n] < target) begin
            @(posedge clk); #1;
            c++;
            if (c > 1000) begin ok = 1'b0; break; end
        end
    endtask

    // number of logged bytes that differ from the source packet
    function automatic int pkt_bad(input int lg, input int n, input int ms, input int cnt, input int tot);
        int b;
        b = 0;
        for (int k = 0; k < cnt; k++) begin
            if (log_data[lg + k] !== mem[n][ms + k] || log_sop[lg + k] !== (k == 0) ||
                log_eop[lg + k] !== (k == tot - 1) || log_port[lg + k] !== 2'(n))
                b++;
        end
        return b;
    endfunction

    function automatic logic [SW-1:0] exp_cnt(input int n);
        return STATS ? SW'(mcnt[n]) : '0;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        for (int n = 0; n < 4; n++) mcnt[n] = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    int ms1;

    task automatic test_reset();
        logic [15:0] outs;
        load_pkt(1, 3, ms1);
        repeat (3) @(posedge clk);
        #1;
        outs = {read_0, read_1, read_2, read_3, sink_valid, sink_sop, sink_eop, pkt_err, sink_data};
        nchk++;
        if (outs !== 16'h0) begin nerr++; $display("FAIL reset_strobes: got %h want 0", outs); end
        nchk++;
        if (sink_port !== 2'd0) begin nerr++; $display("FAIL reset_port: got %0d want 0", sink_port); end
        nchk++;
        if (pkt_cnt !== '0) begin nerr++; $display("FAIL reset_cnt: got %h want 0", pkt_cnt); end
        nchk++;
        if (rd_seen[1] !== 0) begin nerr++; $display("FAIL reset_reads: got %0d want 0", rd_seen[1]); end
    endtask

    task automatic test_single();
        int b0, r1;
        bit ok;
        b0 = nb;
        r1 = rd_seen[1];
        reset = 1'b1;
        wait_bytes(b0 + 7, ok);
        repeat (3) @(posedge clk);
        #1;
        mcnt[1]++;
        nchk++;
        if (!ok) begin nerr++; $display("FAIL single_timeout: got %0d bytes want 7", nb - b0); end
        nchk++;
        if (rd_seen[1] - r1 !== 7) begin nerr++; $display("FAIL single_reads: got %0d want 7", rd_seen[1] - r1); end
        nchk++;
        if (nb - b0 !== 7) begin nerr++; $display("FAIL single_bytes: got %0d want 7", nb - b0); end
        nchk++;
        if (pkt_bad(b0, 1, ms1, 7, 7) !== 0) begin nerr++; $display("FAIL single_stream: got %0d bad bytes want 0", pkt_bad(b0, 1, ms1, 7, 7)); end
        nchk++;
        if (pkt_cnt[1*SW +: SW] !== exp_cnt(1)) begin nerr++; $display("FAIL single_cnt: got %0d want %0d", pkt_cnt[1*SW +: SW], exp_cnt(1)); end
        nchk++;
        if (rd_seen[0] + rd_seen[2] + rd_seen[3] !== 0) begin nerr++; $display("FAIL single_other_reads: got %0d want 0", rd_seen[0] + rd_seen[2] + rd_seen[3]); end
    endtask

    task automatic test_rr();
        int b0, m0a, m2, m3, m0b;
        int exp_port [4] = '{0, 2, 3, 0};
        int exp_ms [4];
        bit ok;
        do_reset();
        b0 = nb;
        load_pkt(0, 2, m0a);
        load_pkt(0, 2, m0b);
        load_pkt(2, 2, m2);
        load_pkt(3, 2, m3);
        exp_ms = '{m0a, m2, m3, m0b};
        wait_bytes(b0 + 24, ok);
        repeat (3) @(posedge clk);
        #1;
        mcnt[0] += 2; mcnt[2]++; mcnt[3]++;
        nchk++;
        if (!ok) begin nerr++; $display("FAIL rr_timeout: got %0d bytes want 24", nb - b0); end
        for (int p = 0; p < 4; p++) begin
            nchk++;
            if (pkt_bad(b0 + 6 * p, exp_port[p], exp_ms[p], 6, 6) !== 0) begin
                nerr++;
                $display("FAIL rr_order pkt %0d: got port %0d want port %0d", p, log_port[b0 + 6 * p], exp_port[p]);
            end
        end
        nchk++;
        if (pkt_cnt[0 +: SW] !== exp_cnt(0) || pkt_cnt[3*SW +: SW] !== exp_cnt(3)) begin
            nerr++; $display("FAIL rr_cnt: got %0d/%0d want %0d/%0d", pkt_cnt[0 +: SW], pkt_cnt[3*SW +: SW], exp_cnt(0), exp_cnt(3));
        end
    endtask

    task automatic test_len_edge();
        int b0, r2, ma, mb;
        bit ok;
        b0 = nb;
        r2 = rd_seen[2];
        load_pkt(2, 0, ma);
        load_pkt(2, 255, mb);
        wait_bytes(b0 + 263, ok);
        repeat (3) @(posedge clk);
        #1;
        mcnt[2] += 2;
        nchk++;
        if (!ok) begin nerr++; $display("FAIL len_timeout: got %0d bytes want 263", nb - b0); end
        nchk++;
        if (pkt_bad(b0, 2, ma, 4, 4) !== 0) begin nerr++; $display("FAIL len0_stream: got %0d bad want 0", pkt_bad(b0, 2, ma, 4, 4)); end
        nchk++;
        if (pkt_bad(b0 + 4, 2, mb, 259, 259) !== 0) begin nerr++; $display("FAIL len255_stream: got %0d bad want 0", pkt_bad(b0 + 4, 2, mb, 259, 259)); end
        nchk++;
        if (rd_seen[2] - r2 !== 263) begin nerr++; $display("FAIL len_reads: got %0d want 263", rd_seen[2] - r2); end
        nchk++;
        if (pkt_cnt[2*SW +: SW] !== exp_cnt(2)) begin nerr++; $display("FAIL len_cnt: got %0d want %0d", pkt_cnt[2*SW +: SW], exp_cnt(2)); end
    endtask

    task automatic test_stall();
        int b0, r0, ms, rs;
        bit ok;
        b0 = nb;
        r0 = rd_seen[0];
        load_pkt(0, 8, ms);
        wait_reads(0, r0 + 4, ok);
        sink_ready = 1'b0;
        rs = rd_seen[0];
        repeat (5) @(posedge clk);
        #1;
        nchk++;
        if (rd_seen[0] - rs !== 0 || rs - r0 !== 4) begin nerr++; $display("FAIL stall_reads: got %0d during stall after %0d want 0 after 4", rd_seen[0] - rs, rs - r0); end
        sink_ready = 1'b1;
        wait_bytes(b0 + 12, ok);
        repeat (3) @(posedge clk);
        #1;
        mcnt[0]++;
        nchk++;
        if (!ok) begin nerr++; $display("FAIL stall_timeout: got %0d bytes want 12", nb - b0); end
        nchk++;
        if (pkt_bad(b0, 0, ms, 12, 12) !== 0 || nb - b0 !== 12) begin nerr++; $display("FAIL stall_stream: got %0d bytes %0d bad want 12 0", nb - b0, pkt_bad(b0, 0, ms, 12, 12)); end
    endtask

    task automatic test_abort();
        int b0, r0, e0, ms0, ms1b;
        logic [SW-1:0] c0;
        bit ok;
        b0 = nb;
        r0 = rd_seen[0];
        e0 = err_seen;
        c0 = pkt_cnt[0 +: SW];
        load_pkt(0, 6, ms0);
        wait_reads(0, r0 + 5, ok);
        hold[0] = 1'b1;
        load_pkt(1, 1, ms1b);
        wait_bytes(b0 + 10, ok);
        repeat (3) @(posedge clk);
        #1;
        mcnt[1]++;
        nchk++;
        if (!ok) begin nerr++; $display("FAIL abort_timeout: got %0d bytes want 10", nb - b0); end
        nchk++;
        if (err_seen - e0 !== 1) begin nerr++; $display("FAIL abort_err_pulse: got %0d want 1", err_seen - e0); end
        nchk++;
        if (pkt_bad(b0, 0, ms0, 5, 10) !== 0) begin nerr++; $display("FAIL abort_partial: got %0d bad want 0", pkt_bad(b0, 0, ms0, 5, 10)); end
        nchk++;
        if (pkt_bad(b0 + 5, 1, ms1b, 5, 5) !== 0) begin nerr++; $display("FAIL abort_next_grant: got port %0d want 1", log_port[b0 + 5]); end
        nchk++;
        if (pkt_cnt[0 +: SW] !== c0) begin nerr++; $display("FAIL abort_cnt: got %0d want %0d", pkt_cnt[0 +: SW], c0); end
        nchk++;
        if (rd_seen[0] - r0 !== 5) begin nerr++; $display("FAIL abort_reads: got %0d want 5", rd_seen[0] - r0); end
        wr_ptr[0] = rd_ptr[0];
        hold[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int b0, r2, rs, e0, ma, m3;
        logic [15:0] outs;
        bit ok;
        r2 = rd_seen[2];
        load_pkt(2, 6, ma);
        wait_reads(2, r2 + 3, ok);
        reset = 1'b0;
        for (int n = 0; n < 4; n++) mcnt[n] = 0;
        #1;
        outs = {read_0, read_1, read_2, read_3, sink_valid, sink_sop, sink_eop, pkt_err, sink_data};
        nchk++;
        if (outs !== 16'h0 || sink_port !== 2'd0 || pkt_cnt !== '0) begin nerr++; $display("FAIL midreset_outputs: got %h/%0d want 0/0", outs, sink_port); end
        rs = rd_seen[2];
        e0 = err_seen;
        repeat (3) @(posedge clk);
        #1;
        nchk++;
        if (rd_seen[2] - rs !== 0 || err_seen - e0 !== 0) begin nerr++; $display("FAIL midreset_quiet: got %0d reads %0d errs want 0 0", rd_seen[2] - rs, err_seen - e0); end
        wr_ptr[2] = rd_ptr[2];
        b0 = nb;
        load_pkt(3, 1, m3);
        load_pkt(0, 1, ma);
        reset = 1'b1;
        wait_bytes(b0 + 10, ok);
        nchk++;
        if (!ok || pkt_bad(b0, 0, ma, 5, 5) !== 0 || pkt_bad(b0 + 5, 3, m3, 5, 5) !== 0) begin
            nerr++; $display("FAIL midreset_first_grant: got port %0d want 0", log_port[b0]);
        end
        nchk++;
        if (multi !== 0) begin nerr++; $display("FAIL one_hot_reads: got %0d multi-read cycles want 0", multi); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_len_edge();
        test_stall();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
